// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the access controller (master) and the memory (slave).
// Handshake: bus_req rises the cycle after a request is accepted and holds with
// stable addr/we/wdata/be until the cycle after bus_ack; bus_ack is a one-cycle
// completion strobe, and bus_rdata is only meaningful in the cycle bus_ack is high.
interface dmem_access_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store responder: runs one req/ack bus transaction per aligned access,
// stalls the pipeline while it is in flight and returns extended load data.
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [1:0]                 mem_size,
    input  logic                       mem_unsigned,
    input  logic [31:0]                addr,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata,
    output logic                       mem_ready,
    output logic                       misaligned,
    output logic                       bus_error,
    dmem_access_ctrl_if.master         bus,
    output logic [1:0]                 dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] baddr_q, baddr_d;
    logic [31:0] bwdata_q, bwdata_d;
    logic [3:0]  be_q, be_d;
    logic        err_q, err_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;

    logic        req_in;
    logic        aligned;
    logic        accept;
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] load_ext;

    always_comb begin
        req_in = mem_read | mem_write;
        case (mem_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        accept     = (state_q == IDLE) && req_in && aligned;
        misaligned = (state_q == IDLE) && req_in && !aligned;
        mem_ready  = ((state_q == IDLE) && !accept) || (state_q == DONE);
    end

    // Lane select uses the offset latched at accept time, not the live address.
    always_comb begin
        byte_sh = bus.bus_rdata >> {lane_q, 3'b000};
        half_sh = bus.bus_rdata >> {lane_q[1], 4'b0000};
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & byte_sh[7]}}, byte_sh[7:0]};
            2'b01:   load_ext = {{16{~uns_q & half_sh[15]}}, half_sh[15:0]};
            default: load_ext = bus.bus_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        req_d    = req_q;
        we_d     = we_q;
        baddr_d  = baddr_q;
        bwdata_d = bwdata_q;
        be_d     = be_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        size_d   = size_q;
        uns_d    = uns_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    baddr_d = {addr[31:2], 2'b00};
                    lane_d  = addr[1:0];
                    size_d  = mem_size;
                    uns_d   = mem_unsigned;
                    cnt_d   = '0;
                    case (mem_size)
                        2'b00: begin
                            be_d     = 4'b0001 << addr[1:0];
                            bwdata_d = {4{wdata[7:0]}};
                        end
                        2'b01: begin
                            be_d     = 4'b0011 << addr[1:0];
                            bwdata_d = {2{wdata[15:0]}};
                        end
                        default: begin
                            be_d     = 4'b1111;
                            bwdata_d = wdata;
                        end
                    endcase
                end
            end
            BUSY: begin
                if (bus.bus_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = load_ext;
                end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            baddr_q  <= '0;
            bwdata_q <= '0;
            be_q     <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            lane_q   <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            req_q    <= req_d;
            we_q     <= we_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
            be_q     <= be_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
        end
    end

    assign rdata         = rdata_q;
    assign bus_error     = err_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = baddr_q;
    assign bus.bus_wdata = bwdata_q;
    assign bus.bus_be    = be_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: transaction-level model builds per-cycle
// expectations into a queue that one negedge compare process consumes.
module tb_dmem_access_ctrl;
  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata, rdata;
  logic        mem_ready, misaligned, bus_error;
  logic [1:0]  dbg_state;

  dmem_access_ctrl_if bus_if();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(T), .TO_W(3)) dut (
    .clock(clock), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
    .rdata(rdata), .mem_ready(mem_ready), .misaligned(misaligned),
    .bus_error(bus_error), .bus(bus_if), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        mem_ready;
    logic        misaligned;
    logic        bus_req;
    logic        bus_error;
    logic        chk_bus;
    logic        bus_we;
    logic [31:0] rdata;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  exp_t          cur_e;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [31:0]   model_rdata = 32'h0;
  int            obs_stall, obs_req;
  logic [31:0]   obs_addr, obs_wdata;
  logic [3:0]    obs_be;
  logic          obs_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic mr, input logic mis, input logic rq, input logic er,
                          input logic chk, input logic we, input logic [31:0] rd,
                          input logic [31:0] ba, input logic [31:0] bw, input logic [3:0] be);
    exp_t e;
    e = '{mem_ready: mr, misaligned: mis, bus_req: rq, bus_error: er, chk_bus: chk,
          bus_we: we, rdata: rd, bus_addr: ba, bus_wdata: bw, bus_be: be};
    exp_q.push_back(e);
  endtask

  // Reference rules, written as plain arithmetic on the access description.
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] a, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * a)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * (a / 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] a);
    int m;
    m = (sz == 2'd0) ? (1 << a) : (sz == 2'd1) ? (3 << a) : 15;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic bit model_aligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b0;
    return (a % (32'd1 << sz)) == 0;
  endfunction

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      check("mem_ready", {31'b0, mem_ready}, {31'b0, cur_e.mem_ready});
      check("misaligned", {31'b0, misaligned}, {31'b0, cur_e.misaligned});
      check("bus_req", {31'b0, bus_if.bus_req}, {31'b0, cur_e.bus_req});
      check("bus_error", {31'b0, bus_error}, {31'b0, cur_e.bus_error});
      check("rdata", rdata, cur_e.rdata);
      if (cur_e.chk_bus) begin
        check("bus_addr", bus_if.bus_addr, cur_e.bus_addr);
        check("bus_wdata", bus_if.bus_wdata, cur_e.bus_wdata);
        check("bus_be", {28'b0, bus_if.bus_be}, {28'b0, cur_e.bus_be});
        check("bus_we", {31'b0, bus_if.bus_we}, {31'b0, cur_e.bus_we});
      end
    end
    if (!mem_ready) obs_stall++;
    if (bus_if.bus_req) begin
      obs_req++;
      obs_addr  = bus_if.bus_addr;
      obs_wdata = bus_if.bus_wdata;
      obs_be    = bus_if.bus_be;
      obs_we    = bus_if.bus_we;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle();
    cyc();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_size  = 2'($urandom_range(0, 3));
    addr      = $urandom;
    wdata     = $urandom;
    bus_if.bus_ack   = 1'($urandom_range(0, 1));
    bus_if.bus_rdata = $urandom;
    push_exp(1, 0, 0, 0, 0, 0, model_rdata, 0, 0, 0);
  endtask

  // ack_at = 0 means the memory never answers; rst_at > 0 asserts reset in that BUSY cycle.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                        input logic [31:0] rword, input int rst_at);
    logic [31:0] e_addr, e_wd, new_rd;
    logic [3:0]  e_be;
    int          n_busy;
    cyc();
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    addr = a; wdata = wd; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = $urandom;
    if (!model_aligned(sz, a)) begin
      push_exp(1, 1, 0, 0, 0, 0, model_rdata, 0, 0, 0);
      return;
    end
    push_exp(0, 0, 0, 0, 0, 0, model_rdata, 0, 0, 0);
    e_addr = a & ~32'h3;
    e_be   = model_be(sz, a[1:0]);
    e_wd   = model_wdata(sz, wd);
    n_busy = (ack_at > 0) ? ack_at : T;
    for (int i = 1; i <= n_busy; i++) begin
      cyc();
      bus_if.bus_ack   = (i == ack_at);
      bus_if.bus_rdata = (i == ack_at) ? rword : $urandom;
      if (i == rst_at) begin
        reset = 1'b1;
        bus_if.bus_ack = 1'b0;
      end
      push_exp(0, 0, 1, 0, 1, wr, model_rdata, e_addr, e_wd, e_be);
      if (i == rst_at) begin
        cyc();
        reset = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = $urandom;
        model_rdata = 32'h0;
        push_exp(1, 0, 0, 0, 0, 0, model_rdata, 0, 0, 0);
        return;
      end
    end
    cyc();
    bus_if.bus_ack   = 1'($urandom_range(0, 1));
    bus_if.bus_rdata = $urandom;
    if (wr) new_rd = model_rdata;
    else if (ack_at > 0) new_rd = model_load(rword, sz, a[1:0], uns);
    else new_rd = 32'h0;
    model_rdata = new_rd;
    push_exp(1, 0, 0, (ack_at == 0), 0, 0, model_rdata, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int op, k, r;
    logic [1:0] sz;
    logic [31:0] a;
    reset = 1'b1;
    mem_read = 0; mem_write = 0; mem_size = 0; mem_unsigned = 0; addr = 0; wdata = 0;
    bus_if.bus_ack = 0; bus_if.bus_rdata = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    push_exp(1, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 4'h0);
    idle_cycle();

    obs_stall = 0; obs_req = 0;
    access(1, 0, 2'd2, 0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 0);
    #2;
    check("lw_rdata", rdata, 32'hDEAD_BEEF);
    check("lw_bus_addr", obs_addr, 32'h100);
    check("lw_bus_be", {28'b0, obs_be}, 32'hF);
    check("lw_stall_cycles", obs_stall, 4);

    access(1, 0, 2'd0, 0, 32'h103, 32'h0, 1, 32'h8011_2233, 0);
    #2; check("lb_rdata", rdata, 32'hFFFF_FF80);
    access(1, 0, 2'd0, 1, 32'h103, 32'h0, 2, 32'h8011_2233, 0);
    #2; check("lbu_rdata", rdata, 32'h0000_0080);
    access(1, 0, 2'd1, 0, 32'h102, 32'h0, 1, 32'h8011_2233, 0);
    #2; check("lh_rdata", rdata, 32'hFFFF_8011);

    access(0, 1, 2'd1, 0, 32'h202, 32'h0000_ABCD, 2, 32'h0, 0);
    #2;
    check("sh_bus_addr", obs_addr, 32'h200);
    check("sh_bus_be", {28'b0, obs_be}, 32'hC);
    check("sh_bus_wdata", obs_wdata, 32'hABCD_ABCD);
    check("sh_bus_we", {31'b0, obs_we}, 32'h1);
    check("sh_rdata_kept", rdata, 32'hFFFF_8011);

    obs_req = 0;
    access(1, 0, 2'd2, 0, 32'h101, 32'h0, 1, 32'h0, 0);
    access(1, 0, 2'd3, 0, 32'h100, 32'h0, 1, 32'h0, 0);
    idle_cycle();
    #2; check("misaligned_no_req", obs_req, 0);

    obs_req = 0;
    access(1, 0, 2'd2, 0, 32'h300, 32'h0, 0, 32'h0, 0);
    #2;
    check("timeout_req_cycles", obs_req, T);
    check("timeout_rdata", rdata, 32'h0);

    obs_req = 0;
    access(1, 0, 2'd2, 0, 32'h400, 32'h0, 2, 32'h1234_5678, 0);
    access(0, 1, 2'd2, 0, 32'h404, 32'hCAFE_F00D, 1, 32'h0, 0);
    idle_cycle();
    #2;
    check("b2b_req_cycles", obs_req, 3);
    check("b2b_rdata", rdata, 32'h1234_5678);

    access(1, 0, 2'd2, 0, 32'h500, 32'h0, 0, 32'h0, 2);
    idle_cycle();
    #2; check("reset_busy_rdata", rdata, 32'h0);

    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 2);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3 | (a & (sz == 2'd0 ? 32'h3 : sz == 2'd1 ? 32'h2 : 32'h0));
      k  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, T);
      r  = 0;
      if (k == 0 && $urandom_range(0, 9) == 0) r = $urandom_range(1, T);
      access(op != 1, op != 0, sz, 1'($urandom_range(0, 1)), a, $urandom, k, $urandom, r);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    idle_cycle();
    @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Memory-side responder that generates `mem_ready` for the pipeline stall controller.
- Takes load/store requests from the EX/MEM stage and runs a multi-cycle req/ack transaction on the data-memory bus.
- Holds `mem_ready` low while the access is in flight, then returns aligned, sign- or zero-extended load data.
- Flags misaligned accesses and bus timeouts for the trap logic.

Parameters:
- TIMEOUT_CYCLES, 255: number of BUSY cycles without `bus_ack` before the access is aborted with `bus_error`.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  load request from EX/MEM.
- mem_write  in  1  store request from EX/MEM.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- mem_unsigned  in  1  1 = zero-extend load (LBU/LHU).
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- rdata  out  32  extended load data, registered.
- mem_ready  out  1  0 = pipeline must stall.
- misaligned  out  1  combinational misaligned or illegal-size flag.
- bus_error  out  1  one-cycle timeout pulse.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  1 = write, registered.
- bus_addr  out  32  word-aligned address, registered.
- bus_wdata  out  32  lane-replicated store data, registered.
- bus_be  out  4  byte enables, registered.
- bus_ack  in  1  bus completion strobe.
- bus_rdata  in  32  read word, valid with `bus_ack`.

Behaviour:
- Reset:
  - state = IDLE.
  - `rdata`, `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`, `bus_error`, and the counter are all 0.
  - With no request present: `mem_ready` = 1, `misaligned` = 0.
- States:
  - IDLE -> BUSY on an accepted request.
  - BUSY -> DONE on `bus_ack` or timeout.
  - DONE -> IDLE unconditionally.
- Request and alignment rules:
  - Request = `mem_read` | `mem_write`. If both are set, treat it as a write.
  - Aligned means: any byte; half with `addr[0]`=0; word with `addr[1:0]`=0.
  - `mem_size` 11 counts as misaligned.
- IDLE, request aligned:
  - `mem_ready` = 0 combinationally in the same cycle.
  - Register `bus_addr` = {`addr[31:2]`,2'b00}.
  - Register `bus_be`: byte = 0001<<`addr[1:0]`; half = 0011<<`addr[1:0]`; word = 1111.
  - Register `bus_wdata`: byte = {4{`wdata[7:0]`}}; half = {2{`wdata[15:0]`}}; word = `wdata`.
  - Latch `bus_we`, `addr[1:0]`, size and unsigned.
  - Set `bus_req` = 1 for the next cycle. Clear the counter.
- IDLE, request misaligned:
  - `misaligned` = 1 and `mem_ready` = 1 combinationally.
  - No bus transaction, no state change, `rdata` unchanged.
- BUSY:
  - `bus_req` = 1, `mem_ready` = 0, address/data/be stable.
  - `bus_ack` is sampled every BUSY cycle, including the first.
  - On `bus_ack`:
    - Drop `bus_req` next cycle.
    - If the access is a read, write `rdata` = selected lane, sign-extended unless unsigned. Byte lane = `bus_rdata[8*a+7:8*a]`; half lane = `bus_rdata[16*a[1]+15:16*a[1]]`.
    - Stores leave `rdata` unchanged.
    - Go to DONE.
  - No ack: increment the counter. On the BUSY cycle where counter == TIMEOUT_CYCLES-1, go to DONE with `bus_error` = 1 for the DONE cycle, `rdata` = 0 (if a read), and `bus_req` dropped.
- DONE:
  - `mem_ready` = 1 for exactly one cycle so the pipeline advances.
  - Request inputs still hold the old access and are ignored.
  - `rdata` is valid and held until the next completed load.
- Latency: request seen in cycle 0, ack in BUSY cycle k (k ≥ 1), DONE at cycle k+1. Minimum stall is 2 cycles.
- `bus_ack` in IDLE or DONE is ignored.
- Reset in BUSY: `bus_req` = 0 the next cycle, state = IDLE; a late ack has no effect.
- Pipeline flush during BUSY does not cancel the access; it completes normally.

Test Plan:
- LW `addr`=0x100, `bus_ack` in 3rd BUSY cycle with 0xDEADBEEF -> `bus_addr`=0x100, `bus_be`=1111, `mem_ready` low cycles 0–3, high cycle 4 only, `rdata`=0xDEADBEEF.
- LB `addr`=0x103, `bus_rdata`=0x80112233 -> `rdata`=0xFFFFFF80; repeat as LBU -> 0x00000080; LH `addr`=0x102 -> 0xFFFF8011.
- SH `addr`=0x202, `wdata`=0x0000ABCD -> `bus_addr`=0x200, `bus_be`=1100, `bus_wdata`=0xABCDABCD, `bus_we`=1, `rdata` unchanged.
- LW `addr`=0x101, and `mem_size`=11 -> `misaligned`=1, `mem_ready`=1 same cycle, `bus_req` never asserted.
- TIMEOUT_CYCLES=4, LW with no ack -> `bus_req` high 4 cycles, DONE with `bus_error`=1 and `mem_ready`=1 for one cycle, `rdata`=0.
- Back-to-back LW then SW (second request present the cycle after DONE) -> second access starts from IDLE, exactly one bus transaction each; reset during BUSY -> `bus_req`=0 next cycle, late ack ignored, `mem_ready`=1.
